regfile_write_port: RTL and testbench
=====================================

// Module: regfile_write_port
// PURPOSE
//  Write side of the 32-entry CPU register file; the read side is the 32:1 read-mux tree.
//  Accepts one write request per cycle and holds it for one cycle in a pending stage.
//  Commits it through a 5:32 one-hot decoder into 32 DATA_W-bit registers.
//  Exports all register contents flat for the read muxes, plus the pending stage for bypass.
//  Register ZERO_REG (X31) always reads 0 and ignores writes.
// PARAMETERS
//  DATA_W    64  register width in bits
//  NUM_REGS  32  number of architectural registers (must equal 2**ADDR_W)
//  ADDR_W    5   register address width
//  ZERO_REG  31  index of the hardwired-zero register
// PORTS
//  clk         in   1                  single clock; all state updates on posedge
//  reset       in   1                  asynchronous, active-high; clears all state
//  wr_en       in   1                  write request valid this cycle
//  wr_addr     in   ADDR_W             destination register index
//  wr_data     in   DATA_W             data to write
//  regs        out  NUM_REGS*DATA_W    flat register contents; reg k at [k*DATA_W +: DATA_W]
//  pend_valid  out  1                  a captured write awaits commit
//  pend_addr   out  ADDR_W             index of the pending write
//  pend_data   out  DATA_W             data of the pending write
// BEHAVIOUR
//  Reset (asynchronous, active-high, any time):
//   - all registers = 0; pend_valid = 0; pend_addr = 0; pend_data = 0.
//   - A pending write is discarded, not committed.
//   - State holds at reset values while reset is high.
//  Capture at each posedge clk (reset low):
//   - pend_valid <= wr_en && (wr_addr != ZERO_REG).
//   - pend_addr  <= wr_addr.
//   - pend_data  <= wr_data.
//   - pend_addr/pend_data load every cycle; they are only meaningful when pend_valid = 1.
//  Commit at the same posedge:
//   - If pend_valid, reg[pend_addr] <= pend_data.
//   - Commit uses the old pending contents, i.e. the request captured on the previous edge.
//  Latency:
//   - Request presented before edge N is visible on pend_* after edge N.
//   - It is visible on regs after edge N+1.
//   - Readers needing the value earlier bypass from pend_*.
//  Decoder:
//   - we[NUM_REGS-1:0] = pend_valid ? onehot(pend_addr) : 0.
//   - At most one bit of we is set; registers with we = 0 hold their value.
//  Boundary conditions:
//   - Writes to ZERO_REG are dropped at capture: pend_valid = 0, and no register changes at N+1.
//   - regs slice ZERO_REG is constant 0.
//   - Back-to-back writes (edge N addr A, edge N+1 addr B) commit in order at N+1 and N+2.
//   - If A == B, the later data wins.
//   - wr_en = 0 for one cycle inserts a bubble: pend_valid = 0, no commit on the next edge.
//   - Registers not addressed by a commit never change.
//   - Full pipelining: one write per cycle indefinitely, with no stall or backpressure.
// STRUCTURE
//  Shared package regfile_pkg:
//   - constants DATA_W, NUM_REGS, ADDR_W, ZERO_REG.
//   - typedef reg_addr_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0]).
//   - The same package is used by the read-mux tree.
//  Sub-module decoder5_32:
//   - 5-bit addr + enable in, 32-bit one-hot out.
//   - Built from a 2:4 decoder selecting four enabled 3:8 decoders.
//  Top level contains:
//   - pending-stage flops.
//   - a generate loop of NUM_REGS enabled DATA_W-bit registers, with the ZERO_REG slice tied to 0.
// TESTING
//  1. Reset high mid-run, after writing X5 = 64'hDEAD -> all regs = 0 and pend_valid = 0 immediately,
//     before any clk edge.
//  2. wr_en = 1, addr 3, data 64'h1234 at edge N
//     -> after N: pend_valid = 1, pend_addr = 3; after N+1: regs[3] = 64'h1234, others 0.
//  3. Write addr 31, data 64'hFFFF -> pend_valid stays 0; regs[31] = 0 on every following cycle.
//  4. Back-to-back: addr 7 = 64'hA, then addr 7 = 64'hB, then wr_en = 0
//     -> regs[7] = 64'hA after N+1 and 64'hB after N+2; pend_valid = 0 after N+2.
//  5. Sweep addr 0..30 with data = addr + 1 on consecutive cycles, then idle
//     -> regs[k] = k + 1 for k = 0..30, regs[31] = 0; one-hot we checked every cycle.
//  6. Capture addr 9 = 64'h55, then assert reset before the next edge
//     -> regs[9] = 0 after reset is released; the pending write is never committed.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types, used by the write port and the read-mux tree.
package regfile_pkg;
    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_ADDR = ADDR_W'(ZERO_REG);
endpackage

// File: rtl/regfile_decoder5_32.sv
// Enabled 5:32 one-hot decoder: a 2:4 group select gating four 3:8 decoders.
module decoder5_32 (
    input  logic        i_en,
    input  logic [4:0]  i_addr,
    output logic [31:0] o_onehot
);
    logic [3:0] w_grp;

    always_comb begin
        w_grp = 4'b0000;
        if (i_en) begin
            w_grp[i_addr[4:3]] = 1'b1;
        end
    end

    always_comb begin
        o_onehot = 32'b0;
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 8; b++) begin
                o_onehot[g*8 + b] = w_grp[g] && (i_addr[2:0] == 3'(b));
            end
        end
    end
endmodule

// File: rtl/regfile_write_port.sv
// Register-file write side: one-cycle pending stage, then one-hot commit into the register array.
module regfile_write_port
    import regfile_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       pend_valid,
    output logic [ADDR_W-1:0]          pend_addr,
    output logic [DATA_W-1:0]          pend_data
);
    logic                r_pend_valid;
    reg_addr_t           r_pend_addr;
    reg_data_t           r_pend_data;
    logic [NUM_REGS-1:0] w_we;

    // Capture stage: writes to the zero register are dropped here, so they never reach commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else begin
            r_pend_valid <= wr_en && (wr_addr != ZERO_ADDR);
            r_pend_addr  <= wr_addr;
            r_pend_data  <= wr_data;
        end
    end

    assign pend_valid = r_pend_valid;
    assign pend_addr  = r_pend_addr;
    assign pend_data  = r_pend_data;

    decoder5_32 u_dec (
        .i_en     (r_pend_valid),
        .i_addr   (r_pend_addr),
        .o_onehot (w_we)
    );

    // Commit stage: each register loads the previously captured data when its enable is set.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (k == ZERO_REG) begin : g_zero
            logic w_unused_we;
            assign w_unused_we = w_we[k];
            assign regs[k*DATA_W +: DATA_W] = '0;
        end else begin : g_live
            reg_data_t r_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else if (w_we[k]) begin
                    r_q <= r_pend_data;
                end
            end
            assign regs[k*DATA_W +: DATA_W] = r_q;
        end
    end
endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for the register-file write port: latency, zero register, bubbles and reset.
module tb_regfile_write_port;
    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [63:0]   wr_data;
    logic [2047:0] regs;
    logic          pend_valid;
    logic [4:0]    pend_addr;
    logic [63:0]   pend_data;

    int passes = 0;
    int total  = 0;
    logic [63:0] exp_r [32];

    regfile_write_port dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .regs       (regs),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rg(input int k);
        return regs[k*64 +: 64];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("%s reg%0d", tag, k), rg(k), exp_r[k]);
        end
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 32; k++) exp_r[k] = 64'h0;
    endtask

    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 64'h0;
        clear_exp();
        repeat (2) @(posedge clk);
        #1;
        chk("rst pend_valid", {63'h0, pend_valid}, 64'h0);
        chk("rst pend_addr", {59'h0, pend_addr}, 64'h0);
        chk("rst pend_data", pend_data, 64'h0);
        chk_all("rst");
        @(negedge clk);
        reset = 1'b0;

        // Test 1: write X5, then reset mid-cycle clears everything without a clock edge.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD;
        edge_then_sample();
        @(negedge clk);
        wr_en = 1'b0;
        edge_then_sample();
        chk("t1 reg5 written", rg(5), 64'hDEAD);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t1 async pend_valid", {63'h0, pend_valid}, 64'h0);
        chk_all("t1 async");
        @(negedge clk);
        reset = 1'b0;

        // Test 2: single write latency.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234;
        edge_then_sample();
        chk("t2 pend_valid", {63'h0, pend_valid}, 64'h1);
        chk("t2 pend_addr", {59'h0, pend_addr}, 64'd3);
        chk("t2 pend_data", pend_data, 64'h1234);
        chk("t2 reg3 not yet", rg(3), 64'h0);
        @(negedge clk);
        wr_en = 1'b0;
        edge_then_sample();
        exp_r[3] = 64'h1234;
        chk_all("t2 commit");
        chk("t2 bubble pend_valid", {63'h0, pend_valid}, 64'h0);

        // Test 3: writes to X31 are dropped.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF;
        edge_then_sample();
        chk("t3 pend_valid", {63'h0, pend_valid}, 64'h0);
        @(negedge clk);
        wr_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            edge_then_sample();
            chk_all($sformatf("t3 c%0d", c));
        end

        // Test 4: back-to-back same address, later data wins.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hA;
        edge_then_sample();
        chk("t4 N pend_data", pend_data, 64'hA);
        chk("t4 N reg7", rg(7), 64'h0);
        @(negedge clk);
        wr_data = 64'hB;
        edge_then_sample();
        chk("t4 N+1 reg7", rg(7), 64'hA);
        chk("t4 N+1 pend_data", pend_data, 64'hB);
        @(negedge clk);
        wr_en = 1'b0;
        edge_then_sample();
        chk("t4 N+2 reg7", rg(7), 64'hB);
        chk("t4 N+2 pend_valid", {63'h0, pend_valid}, 64'h0);
        exp_r[7] = 64'hB;
        chk_all("t4 final");

        // Test 5: sweep 0..30 at full rate; every cycle only the committed register changes.
        for (int a = 0; a <= 30; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 64'(a + 1);
            edge_then_sample();
            if (a > 0) exp_r[a-1] = 64'(a);
            chk($sformatf("t5 pend a%0d", a), {63'h0, pend_valid}, 64'h1);
            chk_all($sformatf("t5 a%0d", a));
        end
        @(negedge clk);
        wr_en = 1'b0;
        edge_then_sample();
        exp_r[30] = 64'd31;
        chk_all("t5 idle");

        // Test 6: a captured write is discarded by reset.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h55;
        edge_then_sample();
        chk("t6 pend_valid", {63'h0, pend_valid}, 64'h1);
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6 rst pend_valid", {63'h0, pend_valid}, 64'h0);
        edge_then_sample();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) edge_then_sample();
        clear_exp();
        chk("t6 reg9", rg(9), 64'h0);
        chk_all("t6 after");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
